// File: rtl/right_shift_unit_if.sv
// Command/result bundle for the multi-cycle right shifter.
// The master issues commands; the shifter (slave) reports handshake state and the result.
interface right_shift_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        arith;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, a, b, arith,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, a, b, arith,
        output ready, busy, done, result
    );
endinterface

// File: rtl/right_shift_unit.sv
// Multi-cycle 32-bit logical/arithmetic right shifter: one barrel stage (1,2,4,8,16) per clock.
//   state   | meaning
//   S_IDLE  | waiting for a command, ready=1
//   S_SHIFT | applying stage k, busy=1
//   S_DONE  | one-cycle done pulse, accepts a new command
module right_shift_unit (
    input  logic              clk,
    input  logic              rst_n,
    right_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        fill_q, fill_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            w_q      <= 32'd0;
            shamt_q  <= 5'd0;
            fill_q   <= 1'b0;
            k_q      <= 3'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            shamt_q  <= shamt_d;
            fill_q   <= fill_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        shamt_d  = shamt_q;
        fill_d   = fill_q;
        k_d      = k_q;
        result_d = result_q;
        step     = 5'd1 << k_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    shamt_d = bus.b[4:0];
                    fill_d  = bus.arith & bus.a[31];
                    k_d     = 3'd0;
                    // Any amount above 31 shifts every bit out: skip straight to the fill word.
                    if (|bus.b[31:5]) begin
                        w_d      = {32{bus.arith & bus.a[31]}};
                        result_d = {32{bus.arith & bus.a[31]}};
                        state_d  = S_DONE;
                    end else begin
                        w_d     = bus.a;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (shamt_q[k_q]) begin
                    if (fill_q) begin
                        w_d = 32'($signed(w_q) >>> step);
                    end else begin
                        w_d = w_q >> step;
                    end
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd4) begin
                    result_d = w_d;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q == S_SHIFT);
    assign bus.ready  = (state_q != S_SHIFT);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: doc/right_shift_unit.md
# right_shift_unit

Multi-cycle 32-bit right shifter, logical or arithmetic, complementing the ALU's combinational left-shift path. It takes an operand and a 32-bit shift amount through a start/done handshake. It applies one barrel stage (1, 2, 4, 8, 16) per clock and holds the result until the next command. It sits beside the ALU and serves the `srl`/`sra`/`srlv`/`srav` instructions when the multi-cycle datapath stalls on `busy`.

## Interface
- Parameters: none (32-bit datapath, 5-bit effective shift amount, fixed).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only when `ready`=1.
- `A`  in  32  operand to shift.
- `B`  in  32  shift amount, unsigned, full 32 bits examined.
- `arith`  in  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
- `ready`  out  1  unit can accept `start` this cycle.
- `busy`  out  1  shift in progress.
- `done`  out  1  one-cycle pulse: `result` valid and newly updated.
- `result`  out  32  shifted value; held stable from `done` until the next accepted `start`.

## Operation
- States:
  - IDLE: `ready`=1.
  - SHIFT: `busy`=1, `ready`=0.
  - DONE: `done`=1, `ready`=1.
- IDLE + `start` -> capture `A` into working register W, capture `B[4:0]` into shamt, capture `arith`, clear stage counter k=0.
  - If `B` > 31: go to DONE with W = fill word. Fill word = 32{A[31]} if `arith`=1, else 0.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - If shamt[k]=1: W <= W >> (1<<k). Vacated MSBs take the fill bit, captured A[31] when arithmetic, 0 otherwise.
  - If shamt[k]=0: W unchanged.
  - k <= k+1. After stage k=4, go to DONE.
- DONE lasts exactly one cycle. `start` in DONE is accepted exactly as in IDLE (back-to-back commands). Otherwise go to IDLE.
- `result` = W, registered; it changes only on entry to DONE.
- `start` while in SHIFT is ignored; no queuing, no error flag.
- Input changes after capture do not affect the in-flight operation.
- B = 0 still traverses all 5 stages; result = A.

## Timing
- Reset (async assert, any state): state=IDLE, W=0, k=0, `result`=0x00000000, `ready`=1, `busy`=0, `done`=0. Reset mid-SHIFT aborts the operation and produces no `done`.
- Release of `rst_n` is synchronous to `clk` at the board level; the first accepted `start` is on the first edge after release.
- Capture edge E0 (`start`=1, `ready`=1).
  - Normal path: stages applied at edges E1..E5. `done`=1 and `result` valid in the cycle after E5. Latency is 6 edges from capture to `done`, fixed regardless of shift amount.
  - Saturated path (`B` > 31): `done`=1 in the cycle after E0. Latency is 1 edge.
- `busy`=1 exactly during the cycles following E0..E4 on the normal path; `busy` is never 1 on the saturated path.
- `ready` = !`busy`. All outputs are registered or decoded from state only, with no combinational path from inputs.
- Throughput: one normal command per 6 cycles with back-to-back `start` in DONE; one saturated command per cycle.

## Test plan
- Arithmetic shift: A=0x80000000, B=4, arith=1, pulse `start` -> `busy` for 5 cycles, then a 1-cycle `done` with `result`=0xF8000000. Repeat with arith=0 -> 0x08000000.
- Saturation: A=0x80000001, B=32, arith=1 -> `done` the cycle after capture, `result`=0xFFFFFFFF, `busy` never asserted. Same with arith=0 -> 0x00000000. B=0xFFFFFFFF, arith=0 -> 0x00000000.
- Zero and maximum shift:
  - A=0x12345678, B=0 -> `result`=0x12345678 after full 6-edge latency.
  - B=31, A=0x7FFFFFFF, arith=1 -> 0x00000000.
  - B=31, A=0x80000000, arith=1 -> 0xFFFFFFFF.
- Busy protection: start A=0xF0000000, B=8, arith=0. Assert `start` with A=0xFFFFFFFF, B=1 during SHIFT, and change A/B mid-shift -> single `done`, `result`=0x00F00000. The second `start` is ignored.
- Back-to-back: hold `start` high across DONE with a new command A=0x00000100, B=8 -> second `done` 6 edges later, `result`=0x00000001. The first `result` stays stable until the second `done`.
- Reset mid-operation: assert `rst_n`=0 asynchronously during the 3rd SHIFT cycle -> outputs immediately show `result`=0, `ready`=1, `busy`=0, `done`=0. No `done` follows. A fresh command after release completes normally.
